// File: rtl/jzjcoref_io_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package    : jzjcoref_io_pkg                                               |
// | Description: Shared constants and helpers for JZJCoreF board I/O logic.    |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
package jzjcoref_io_pkg;

    localparam int CLOCK_HZ                = 50000000;
    localparam int DEFAULT_SYNC_STAGES     = 2;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;

    // Number of core clock cycles spanning the given number of milliseconds.
    function automatic int debounce_cycles(input int ms);
        return (CLOCK_HZ / 1000) * ms;
    endfunction

endpackage
`default_nettype wire

// File: rtl/debounce_bit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : debounce_bit                                                  |
// | Description: One input bit: synchroniser, stability-window debouncer and   |
// |              registered rise/fall pulses.                                  |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module debounce_bit #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clock,
    input  logic notReset,
    input  logic rawIn,
    output logic debounced,
    output logic risePulse,
    output logic fallPulse
);

    localparam int                     c_COUNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_COUNT_W-1:0]   c_LAST    = c_COUNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_COUNT_W-1:0]   c_ONE     = c_COUNT_W'(1);

    if (SYNC_STAGES < 2) begin : g_bad_sync_stages
        $error("debounce_bit: SYNC_STAGES must be >= 2");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce_cycles
        $error("debounce_bit: DEBOUNCE_CYCLES must be >= 1");
    end

    logic [SYNC_STAGES-1:0] r_sync;
    logic [c_COUNT_W-1:0]   r_count;
    logic                   r_debounced;
    logic                   r_rise;
    logic                   r_fall;
    logic                   w_synced;

    assign w_synced  = r_sync[SYNC_STAGES-1];
    assign debounced = r_debounced;
    assign risePulse = r_rise;
    assign fallPulse = r_fall;

    always_ff @(posedge clock or negedge notReset) begin
        if (!notReset) begin
            r_sync      <= '0;
            r_count     <= '0;
            r_debounced <= 1'b0;
            r_rise      <= 1'b0;
            r_fall      <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], rawIn};
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            // Any return to the accepted level restarts the stability window.
            if (w_synced == r_debounced) begin
                r_count <= '0;
            end else if (r_count == c_LAST) begin
                r_debounced <= w_synced;
                r_count     <= '0;
                r_rise      <= w_synced;
                r_fall      <= ~w_synced;
            end else begin
                r_count <= r_count + c_ONE;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/port_input_debouncer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : port_input_debouncer                                          |
// | Description: Conditions raw board inputs for JZJCoreF port E; one          |
// |              independent debounce_bit per input.                           |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module port_input_debouncer
    import jzjcoref_io_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic             clock,
    input  logic             notReset,
    input  logic [WIDTH-1:0] rawIn,
    output logic [WIDTH-1:0] debounced,
    output logic [WIDTH-1:0] risePulse,
    output logic [WIDTH-1:0] fallPulse
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_debounce_bit (
            .clock     (clock),
            .notReset  (notReset),
            .rawIn     (rawIn[i]),
            .debounced (debounced[i]),
            .risePulse (risePulse[i]),
            .fallPulse (fallPulse[i])
        );
    end

endmodule
`default_nettype wire
